// File: rtl/store_buffer.sv
// store_buffer: word-wide store queue sitting in front of a single-port,
// byte-addressed data memory. Stores are accepted in one cycle and drained to
// memory whenever no load needs the shared port.
//
// Optional feature macro: STORE_BUFFER_FWD_EN
//   defined   - loads that hit a buffered address get the youngest match
//               forwarded; ld_stall is tied low.
//   undefined - no forwarding; a load that matches any buffered entry stalls
//               while draining proceeds, then reads memory.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_stall,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    logic [AW-1:0]   entry_addr_q [DEPTH];
    logic [DW-1:0]   entry_data_q [DEPTH];

    logic            push;
    logic            pop;
    logic            ld_hit;
    logic            ld_grant;
    logic [DEPTH-1:0] age_match;

    // age_match[k] flags the k-th oldest valid entry whose address equals ld_addr
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PW-1:0] slot;
        assign slot          = head_q + PW'(gi);
        assign age_match[gi] = ((PW+1)'(gi) < count_q) && (entry_addr_q[slot] == ld_addr);
    end

    assign ld_hit = |age_match;

`ifdef STORE_BUFFER_FWD_EN
    logic [DW-1:0] fwd_data;

    // scan oldest to youngest so the youngest matching entry overrides older ones
    always_comb begin
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_match[k]) begin
                fwd_data = entry_data_q[head_q + PW'(k)];
            end
        end
    end
`endif

    // load result, stall, and port arbitration (load has priority over draining)
    always_comb begin
`ifdef STORE_BUFFER_FWD_EN
        ld_stall = 1'b0;
        ld_data  = ld_hit ? fwd_data : mem_rd;
`else
        ld_stall = ld_req && ld_hit;
        ld_data  = mem_rd;
`endif
        ld_grant    = ld_req && !ld_stall;
        mem_we      = !ld_grant && (count_q != '0);
        mem_address = ld_grant ? ld_addr : entry_addr_q[head_q];
        mem_wd      = entry_data_q[head_q];
    end

    // pointer and occupancy next-state; readiness ignores a same-cycle pop
    always_comb begin
        st_ready = (count_q != (PW+1)'(DEPTH));
        empty    = (count_q == '0);
        push     = st_valid && st_ready;
        pop      = mem_we;
        head_d   = pop  ? head_q + 1'b1 : head_q;
        tail_d   = push ? tail_q + 1'b1 : tail_q;
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    // pointer/count registers; reset discards every buffered store at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // entry storage written at the tail; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr_q[tail_q] <= st_addr;
            entry_data_q[tail_q] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
// Bench for store_buffer: queue-based reference model plus directed scenarios.
// Works in either build (STORE_BUFFER_FWD_EN defined or not).
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ready;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic [31:0] mem_address;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;
    logic        empty;

    int n_assert = 0;
    int n_fail   = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
        .mem_address(mem_address), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .empty(empty)
    );

    always #5 clk = ~clk;

    // data memory written by the DUT, and the golden memory written by the model
    logic [31:0] dmem [0:255];
    logic [31:0] gmem [0:255];
    assign mem_rd = dmem[mem_address[9:2]];

    initial begin : data_memory
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 32'h0;
        end
        dmem[8'h10] = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            if (mem_we) dmem[mem_address[9:2]] = mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: an ordered list of pending stores, oldest first
    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    ent_t q[$];

    task automatic model_view(output bit hit, output logic [31:0] yd,
                              output bit stall_m, output bit we_m, output bit grant_m);
        hit = 1'b0;
        yd  = '0;
        foreach (q[i]) begin
            if (q[i].a == ld_addr) begin
                hit = 1'b1;
                yd  = q[i].d;
            end
        end
`ifdef STORE_BUFFER_FWD_EN
        stall_m = 1'b0;
`else
        stall_m = ld_req && hit;
`endif
        grant_m = ld_req && !stall_m;
        we_m    = !grant_m && (q.size() != 0);
    endtask

    task automatic check_cycle();
        bit hit, stall_m, we_m, grant_m;
        logic [31:0] yd;
        if (!rst) begin
            q.delete();
            check("rst_st_ready", st_ready, 1);
            check("rst_empty", empty, 1);
            check("rst_mem_we", mem_we, 0);
            check("rst_ld_stall", ld_stall, 0);
            return;
        end
        model_view(hit, yd, stall_m, we_m, grant_m);
        check("st_ready", st_ready, (q.size() != DEPTH));
        check("empty", empty, (q.size() == 0));
        check("ld_stall", ld_stall, stall_m);
        check("mem_we", mem_we, we_m);
        if (grant_m) begin
            check("mem_address_ld", mem_address, ld_addr);
`ifdef STORE_BUFFER_FWD_EN
            check("ld_data", ld_data, hit ? yd : gmem[ld_addr[9:2]]);
`else
            check("ld_data", ld_data, gmem[ld_addr[9:2]]);
`endif
        end else if (we_m) begin
            check("mem_address_drain", mem_address, q[0].a);
            check("mem_wd_drain", mem_wd, q[0].d);
        end
    endtask

    task automatic update_model();
        bit hit, stall_m, we_m, grant_m, acc;
        logic [31:0] yd;
        if (!rst) begin
            q.delete();
            return;
        end
        model_view(hit, yd, stall_m, we_m, grant_m);
        acc = st_valid && (q.size() != DEPTH);
        if (we_m) begin
            $display("drain  addr=%h data=%h", q[0].a, q[0].d);
            gmem[q[0].a[9:2]] = q[0].d;
            void'(q.pop_front());
        end
        if (acc) begin
            $display("store  addr=%h data=%h", st_addr, st_data);
            q.push_back('{a: st_addr, d: st_data});
        end
    endtask

    initial begin : model
        for (int i = 0; i < 256; i++) begin
            gmem[i] = 32'h0;
        end
        gmem[8'h10] = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            update_model();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name, input int max_cycles);
        int n = 0;
        while (!empty && n < max_cycles) begin
            step();
            n++;
        end
        check(name, empty, 1);
    endtask

    initial begin : stimulus
        // reset
        repeat (3) step();
        check("init_st_ready", st_ready, 1);
        check("init_empty", empty, 1);
        check("init_mem_we", mem_we, 0);
        check("init_ld_stall", ld_stall, 0);
        rst = 1'b1;
        step();

        // fill under continuous loads, overflow attempt, then drain in order
        ld_req = 1'b1; ld_addr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h10 + 32'(4 * i); st_data = 32'hA0 + 32'(i);
            step();
        end
        check("fill_st_ready", st_ready, 0);
        st_addr = 32'h50; st_data = 32'hBAD;
        step();
        check("overflow_st_ready", st_ready, 0);
        check("starve_ld_data", ld_data, 32'hDEADBEEF);
        st_valid = 1'b0; ld_req = 1'b0;
        repeat (3) step();
        check("drain3_empty", empty, 0);
        step();
        check("drain4_empty", empty, 1);
        for (int i = 0; i < 4; i++) begin
            check("fill_mem", dmem[4 + i], 32'hA0 + 32'(i));
        end
        check("overflow_not_written", dmem[20], 32'h0);

        // push and drain in the same cycle while holding DEPTH-1, tail wrap
        ld_req = 1'b1; ld_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'h60 + 32'(4 * i); st_data = 32'hB0 + 32'(i);
            step();
        end
        ld_req = 1'b0;
        st_addr = 32'h6C; st_data = 32'hB3;
        step();
        check("wrap_st_ready", st_ready, 1);
        check("wrap_empty", empty, 0);
        st_addr = 32'h70; st_data = 32'hB4;
        step();
        st_valid = 1'b0;
        wait_empty("wrap_drain_timeout", 10);
        for (int i = 0; i < 5; i++) begin
            check("wrap_mem", dmem[24 + i], 32'hB0 + 32'(i));
        end

        // two stores to the same address, then a load of it
        ld_req = 1'b1; ld_addr = 32'h40;
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h11111111;
        step();
        st_data = 32'h22222222;
        step();
        st_valid = 1'b0; ld_addr = 32'h20;
        #1;
`ifndef STORE_BUFFER_FWD_EN
        check("dup_stall_first", ld_stall, 1);
`endif
        for (int n = 0; n < 10 && ld_stall; n++) begin
            step();
        end
        check("dup_stall_timeout", ld_stall, 0);
        check("dup_ld_data", ld_data, 32'h22222222);
        ld_req = 1'b0;
        wait_empty("dup_drain_timeout", 10);
        check("dup_mem", dmem[8], 32'h22222222);

        // load miss against a non-matching buffered entry
        ld_req = 1'b1; ld_addr = 32'h40;
        st_valid = 1'b1; st_addr = 32'h44; st_data = 32'h77;
        step();
        st_valid = 1'b0;
        #1;
        check("miss_ld_data", ld_data, 32'hDEADBEEF);
        check("miss_mem_we", mem_we, 0);
        check("miss_ld_stall", ld_stall, 0);
        ld_req = 1'b0;
        wait_empty("miss_drain_timeout", 10);
        check("miss_mem", dmem[17], 32'h77);

        // load right behind a store to the same address
        st_valid = 1'b1; st_addr = 32'h30; st_data = 32'h5;
        step();
        st_valid = 1'b0; ld_req = 1'b1; ld_addr = 32'h30;
        #1;
`ifdef STORE_BUFFER_FWD_EN
        check("hit_fwd_data", ld_data, 32'h5);
        check("hit_mem_we", mem_we, 0);
`else
        check("hit_stall", ld_stall, 1);
        check("hit_mem_we", mem_we, 1);
`endif
        step();
        check("hit_stall_after", ld_stall, 0);
        check("hit_ld_data", ld_data, 32'h5);
        ld_req = 1'b0;
        wait_empty("hit_drain_timeout", 10);
        check("hit_mem", dmem[12], 32'h5);

        // asynchronous reset while three entries are draining
        ld_req = 1'b1; ld_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'h80 + 32'(4 * i); st_data = 32'hC0 + 32'(i);
            step();
        end
        st_valid = 1'b0; ld_req = 1'b0;
        #1;
        check("pre_rst_mem_we", mem_we, 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_mem_we", mem_we, 0);
        check("arst_empty", empty, 1);
        check("arst_st_ready", st_ready, 1);
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        check("post_rst_empty", empty, 1);
        for (int i = 0; i < 3; i++) begin
            check("rst_no_write", dmem[32 + i], 32'h0);
        end

        // final memory image against the model's
        for (int i = 0; i < 64; i++) begin
            check("mem_image", dmem[i], gmem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
